// File: rtl/stat_rd_ctrl.sv
// Read-side initiator for the per-flow statistics memory: single-flow or full-sweep reads,
// fixed read latency capture, valid/ready result port. Define STAT_RD_CLEAR_EN for the clear stage.
module stat_rd_ctrl #(
    parameter int A_WIDTH    = 10,
    parameter int D_WIDTH    = 32,
    parameter int RD_LATENCY = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_sweep_i,
    input  logic [A_WIDTH-1:0] req_flow_num_i,
    input  logic               abort_i,
    output logic               read_flag_from_mem_o,
    output logic [A_WIDTH-1:0] rd_flow_num_o,
    input  logic               mem_ready_i,
    input  logic [D_WIDTH-1:0] rd_data_i,
    output logic               stat_valid_o,
    input  logic               stat_ready_i,
    output logic [A_WIDTH-1:0] stat_flow_num_o,
    output logic [D_WIDTH-1:0] stat_data_o,
    output logic               stat_last_o,
`ifdef STAT_RD_CLEAR_EN
    output logic               clr_flag_o,
    output logic [A_WIDTH-1:0] clr_flow_num_o,
`endif
    output logic               busy_o
);

`ifdef STAT_RD_CLEAR_EN
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUT, CLEAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;
`endif

    localparam logic [2:0]         LAT_INIT  = 3'(RD_LATENCY - 1);
    localparam logic [A_WIDTH-1:0] LAST_FLOW = '1;

    state_t               state_q, state_d;
    logic [A_WIDTH-1:0]   flow_q, flow_d;
    logic                 sweep_q, sweep_d;
    logic [2:0]           lat_q, lat_d;
    logic                 abort_q, abort_d;
    logic [D_WIDTH-1:0]   data_q, data_d;
    logic [A_WIDTH-1:0]   sflow_q, sflow_d;
    logic                 is_last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            flow_q  <= '0;
            sweep_q <= 1'b0;
            lat_q   <= '0;
            abort_q <= 1'b0;
            data_q  <= '0;
            sflow_q <= '0;
        end else begin
            state_q <= state_d;
            flow_q  <= flow_d;
            sweep_q <= sweep_d;
            lat_q   <= lat_d;
            abort_q <= abort_d;
            data_q  <= data_d;
            sflow_q <= sflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        flow_d  = flow_q;
        sweep_d = sweep_q;
        lat_d   = lat_q;
        abort_d = abort_q;
        data_d  = data_q;
        sflow_d = sflow_q;
        // Sweep ends on the all-ones flow so the counter never wraps back to 0.
        is_last = !sweep_q || (flow_q == LAST_FLOW);
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    sweep_d = req_sweep_i;
                    flow_d  = req_sweep_i ? '0 : req_flow_num_i;
                    abort_d = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (mem_ready_i) begin
                    lat_d   = LAT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // An abort here lets the outstanding read land, then drops its data.
                if (abort_i) abort_d = 1'b1;
                if (lat_q == '0) begin
                    if (abort_i || abort_q) begin
                        state_d = IDLE;
                    end else begin
                        data_d  = rd_data_i;
                        sflow_d = flow_q;
                        state_d = OUT;
                    end
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            OUT: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (stat_ready_i) begin
`ifdef STAT_RD_CLEAR_EN
                    state_d = CLEAR;
`else
                    if (is_last) begin
                        state_d = IDLE;
                    end else begin
                        flow_d  = flow_q + 1'b1;
                        state_d = ISSUE;
                    end
`endif
                end
            end
`ifdef STAT_RD_CLEAR_EN
            CLEAR: begin
                if (abort_i || is_last) begin
                    state_d = IDLE;
                end else begin
                    flow_d  = flow_q + 1'b1;
                    state_d = ISSUE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign req_ready_o          = (state_q == IDLE);
    assign busy_o               = (state_q != IDLE);
    assign read_flag_from_mem_o = (state_q == ISSUE);
    assign rd_flow_num_o        = (state_q == ISSUE) ? flow_q : '0;
    assign stat_valid_o         = (state_q == OUT);
    assign stat_last_o          = (state_q == OUT) && is_last;
    assign stat_flow_num_o      = sflow_q;
    assign stat_data_o          = data_q;
`ifdef STAT_RD_CLEAR_EN
    assign clr_flag_o           = (state_q == CLEAR);
    assign clr_flow_num_o       = (state_q == CLEAR) ? flow_q : '0;
`endif

endmodule
